// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file (regfile_mp).
package regfile_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = $clog2(NREGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]   reg_data_t;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: zeroes registers 1..NREGS-1, one per cycle,
// then enters RUN and raises ready_o.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS  = NREGS_DEF,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              run_o,
    output logic              ready_o
);

    localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(NREGS - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            RF_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RF_RUN;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= RF_CLEAR;
            cnt_q   <= CNT_FIRST;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign clr_we_o   = (state_q == RF_CLEAR);
    assign clr_addr_o = cnt_q;
    assign run_o      = (state_q == RF_RUN);
    assign ready_o    = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with youngest-port write priority,
// hard-wired x0 and a post-reset clear. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NUM_WR = 2,
    parameter  int unsigned NUM_RD = 4,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
    output logic                     ready_o
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              wr_ok;

    logic [NUM_WR-1:0] wr_en;
    logic [ADDR_W-1:0] wr_addr [NUM_WR];
    logic [XLEN-1:0]   wr_data [NUM_WR];
    logic [XLEN-1:0]   regs    [NREGS];

    regfile_clear_seq #(
        .NREGS (NREGS)
    ) u_clear_seq (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .run_o      (run),
        .ready_o    (ready_o)
    );

    assign wr_ok = run & ~reset_i;

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        assign wr_addr[w] = wr_addr_i[w*ADDR_W +: ADDR_W];
        assign wr_data[w] = wr_data_i[w*XLEN +: XLEN];
        assign wr_en[w]   = wr_en_i[w] & wr_ok & (wr_addr[w] != '0);
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign regs[r] = '0;
        end else begin : g_store
            logic [XLEN-1:0] reg_q, reg_d;

            // Ascending scan: the last matching (youngest) port overrides older ones.
            always_comb begin
                reg_d = reg_q;
                if (clr_we && (clr_addr == ADDR_W'(r))) begin
                    reg_d = '0;
                end
                for (int unsigned w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && (wr_addr[w] == ADDR_W'(r))) begin
                        reg_d = wr_data[w];
                    end
                end
            end

            always_ff @(posedge clock_i) begin
                reg_q <= reg_d;
            end

            assign regs[r] = reg_q;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [XLEN-1:0]   rd_q, rd_d;

        assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_d = regs[ra];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w] == ra)) begin
                    rd_d = wr_data[w];
                end
            end
`endif
            if (!run || (ra == '0)) begin
                rd_d = '0;
            end
        end

        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd_data_o[k*XLEN +: XLEN] = rd_q;
    end

endmodule
